// File: rtl/sprite_pkg.sv
// Shared sizes, types and helpers for the sprite row fetcher.
package sprite_pkg;

  localparam int SPR_W    = 32;
  localparam int SPR_H    = 32;
  localparam int PIX_BITS = 3;
  localparam int ADDR_W   = 10;
  localparam int COL_W    = $clog2(SPR_W);
  localparam int ROW_W    = $clog2(SPR_H);

  typedef logic [PIX_BITS-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // A width of 0 or anything wider than the line buffer means a full row.
  function automatic logic [COL_W:0] clamp_w(input logic [COL_W:0] w);
    if (w == '0 || w > (COL_W+1)'(SPR_W)) return (COL_W+1)'(SPR_W);
    return w;
  endfunction

endpackage

// File: rtl/sprite_line_buf.sv
// One-row pixel buffer: synchronous write, synchronous clear-all, async read.
module sprite_line_buf
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  input  logic                we,
  input  logic [COL_W-1:0]    wr_idx,
  input  logic [PIX_BITS-1:0] wr_data,
  input  logic [COL_W-1:0]    rd_idx,
  output logic [PIX_BITS-1:0] rd_data
);

  pix_t mem_q [SPR_W];
  pix_t mem_d [SPR_W];

  // Next buffer contents: clear beats write.
  always_comb begin
    // NOTE: start from the held value so every path assigns mem_d; no latch.
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < SPR_W; i++) mem_d[i] = '0;
    end else if (we) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: no reset branch here; the owner drives clr during reset, which
    // clears the array synchronously. Non-blocking keeps the update atomic.
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sprite_row_fetch.sv
// Walks one sprite row through a 1-cycle-latency ROM into a line buffer.
module sprite_row_fetch
  import sprite_pkg::*;
(
  input  logic                clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [ROW_W-1:0]    row,
  input  logic [COL_W:0]      sprite_w,
  input  logic                flip,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [PIX_BITS-1:0] rom_q,
  output logic                busy,
  output logic                done,
  input  logic [COL_W-1:0]    rd_x,
  output logic [PIX_BITS-1:0] rd_pix,
  output logic                rd_opaque
);

  fetch_state_t     state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W:0]   w_q, w_d;
  logic             flip_q, flip_d;
  logic [COL_W-1:0] k_q, k_d;
  logic             cap_vld_q, cap_vld_d;
  logic [COL_W-1:0] cap_k_q, cap_k_d;
  logic             done_q, done_d;
  logic             accept;
  logic [COL_W:0]   w_m1;
  logic [COL_W-1:0] wr_idx;

  assign w_m1 = w_q - (COL_W+1)'(1);

  // Next-state, latch-at-accept and column counter.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    w_d       = w_q;
    flip_d    = flip_q;
    k_d       = k_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    cap_vld_d = (state_q == ISSUE);
    cap_k_d   = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          row_d   = row;
          w_d     = clamp_w(sprite_w);
          flip_d  = flip;
          k_d     = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // k stops at W-1 so rom_addr holds the last address afterwards.
        if ({1'b0, k_q} == w_m1) state_d = DRAIN;
        else                     k_d     = k_q + 1'b1;
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      w_q       <= (COL_W+1)'(SPR_W);
      flip_q    <= 1'b0;
      k_q       <= '0;
      cap_vld_q <= 1'b0;
      cap_k_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      w_q       <= w_d;
      flip_q    <= flip_d;
      k_q       <= k_d;
      cap_vld_q <= cap_vld_d;
      cap_k_q   <= cap_k_d;
      done_q    <= done_d;
    end
  end

  // Row base plus column; max 31*32+31 fits ADDR_W exactly.
  assign rom_addr = ADDR_W'(row_q) * ADDR_W'(w_q) + ADDR_W'(k_q);

  // Mirrored rows land at W-1-k so the sprite stays left-aligned.
  assign wr_idx = flip_q ? COL_W'(w_m1 - {1'b0, cap_k_q}) : cap_k_q;

  sprite_line_buf u_buf (
    .clk     (clk),
    .clr     (Reset | accept),
    .we      (cap_vld_q),
    .wr_idx  (wr_idx),
    .wr_data (rom_q),
    .rd_idx  (rd_x),
    .rd_data (rd_pix)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_opaque = (rd_pix != '0);

endmodule
